// File: rtl/wide_fifo_ctrl.sv
// Wide-write / narrow-read FIFO pointer and flag controller.
// Optional sticky error flags: define WIDE_FIFO_CTRL_ERR_EN.
module wide_fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
`ifdef WIDE_FIFO_CTRL_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_TH =
    (ADDR_WIDTH+1)'(DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] W_STEP =
    ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] R_STEP =
    ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_w_ptr;
  logic [ADDR_WIDTH-1:0] r_r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Accept decisions from the registered flags; the write
  // strobe is held off while reset is asserted.
  always_comb begin
    w_wr_ok     = wr & ~r_full & ~reset;
    w_rd_ok     = rd & ~r_empty & ~reset;
    w_count_nxt = r_count
                + (ADDR_WIDTH+1)'({w_wr_ok, 1'b0})
                - (ADDR_WIDTH+1)'(w_rd_ok);
  end

  // Pointers, occupancy and flags decoded from next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_ok) r_w_ptr <= r_w_ptr + W_STEP;
      if (w_rd_ok) r_r_ptr <= r_r_ptr + R_STEP;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt > FULL_TH);
      r_empty <= (w_count_nxt == '0);
    end
  end

`ifdef WIDE_FIFO_CTRL_ERR_EN
  logic r_ovf;
  logic r_unf;

  // Sticky records of requests made against the wrong flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr & r_full)  r_ovf <= 1'b1;
      if (rd & r_empty) r_unf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`endif

  assign rf_wr_en = w_wr_ok;
  assign w_addr   = r_w_ptr;
  assign r_addr   = r_r_ptr;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;

endmodule

// File: tb/tb_wide_fifo_ctrl.sv
// Bench for wide_fifo_ctrl: directed steps then random
// traffic, checked against a queue model with a byte store.
module tb_wide_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          rf_wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef WIDE_FIFO_CTRL_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  logic [15:0] w_data;
  logic [7:0]  mem [DEPTH];

  logic [7:0] q[$];
  int npush;
  int npop;
  bit m_ovf;
  bit m_unf;

  int nchk  = 0;
  int npass = 0;

  wide_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .rf_wr_en (rf_wr_en),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .full     (full),
    .empty    (empty),
`ifdef WIDE_FIFO_CTRL_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  // Stand-in register file: two entries per write, async read.
  always @(posedge clk) begin
    if (rf_wr_en) begin
      mem[int'(w_addr)]     <= w_data[7:0];
      mem[int'(w_addr) + 1] <= w_data[15:8];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic bit m_full();
    return q.size() > DEPTH - 2;
  endfunction

  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(m_full()));
    check("w_addr", 32'(w_addr), 32'(npush % DEPTH));
    check("r_addr", 32'(r_addr), 32'(npop % DEPTH));
    if (q.size() != 0)
      check("r_data", 32'(mem[int'(r_addr)]), 32'(q[0]));
`ifdef WIDE_FIFO_CTRL_ERR_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  task automatic step(input bit r, input bit w,
                      input bit d, input logic [15:0] data);
    bit wok;
    bit rok;
    @(negedge clk);
    reset  = r;
    wr     = w;
    rd     = d;
    w_data = data;
    #1;
    wok = !r && w && !m_full();
    rok = !r && d && q.size() != 0;
    check("rf_wr_en", 32'(rf_wr_en), 32'(wok));
    @(posedge clk);
    if (r) begin
      q.delete();
      npush = 0;
      npop  = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (w && m_full())      m_ovf = 1;
      if (d && q.size() == 0) m_unf = 1;
      if (rok) begin
        void'(q.pop_front());
        npop++;
      end
      if (wok) begin
        q.push_back(data[7:0]);
        q.push_back(data[15:8]);
        npush += 2;
      end
    end
    #1;
    check_state();
  endtask

  initial begin
    reset  = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = '0;
    npush  = 0;
    npop   = 0;
    m_ovf  = 0;
    m_unf  = 0;

    step(1, 0, 0, 16'h0);
    step(1, 1, 1, 16'hDEAD);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);

    step(0, 1, 0, 16'hFF0A);
    check("push_waddr", 32'(w_addr), 32'd2);
    check("push_rdata", 32'(mem[int'(r_addr)]), 32'h0A);
    step(0, 0, 1, 16'h0);
    check("pop_rdata", 32'(mem[int'(r_addr)]), 32'hFF);
    step(0, 0, 1, 16'h0);

    step(0, 1, 0, 16'h1122);
    step(0, 1, 0, 16'h3344);
    check("two_push_cnt", 32'(count), 32'd4);
    check("two_push_full", 32'(full), 32'd1);
    step(0, 1, 0, 16'h5566);

    step(0, 0, 1, 16'h0);
    check("odd_full", 32'(full), 32'd1);
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h7788);

    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'h99AA);
    step(0, 1, 1, 16'hBBCC);
    check("sim_cnt", 32'(count), 32'd3);

    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0);
    step(0, 1, 0, 16'hA1B2);
    step(0, 0, 1, 16'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           1'($urandom), 1'($urandom),
           16'($urandom));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
